multicycle_control_unit: RTL and testbench

Control unit for the multicycle ARM-subset datapath: a Moore state machine sequencing fetch, decode, memory, execute and branch steps. It also contains the ALU decoder, PC logic and conditional-execution logic, with internal NZCV flag storage. It sits between the instruction register and the shared-memory multicycle datapath. It supports a wider ALU-control encoding than the single-cycle decoder, adding EOR and an optional MOV.

---
 rtl/multicycle_control_unit.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Moore-style control unit for the multicycle ARM-subset datapath: sequencing FSM, ALU decoder,
// PC/write-enable logic and conditional execution with stored NZCV. MULTICYCLE_MOV_EN adds MOV (cmd 1101).
module multicycle_control_unit #(
    parameter int         ALUCTRL_W = 3,
    parameter logic [3:0] PC_REG    = 4'd15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           Cond,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 NoWrite,
    output logic                 MOVInstr,
    output logic [3:0]           Flags
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    localparam bit EOR_EN = (ALUCTRL_W >= 3);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_EOR = ALUCTRL_W'(4);

    state_t     state_reg, state_next;
    logic [3:0] flags_reg;
    logic       cond_ex_reg;
    logic       cond_ex_next;
    logic       cond_ex;
    logic       next_pc, ir_write, reg_w, mem_w, branch, alu_op;
    logic       adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src;
    logic [ALUCTRL_W-1:0] dec_ctrl;
    logic       dec_supported, dec_arith, dec_cmp, dp_step, pcs;
    logic [1:0] flag_w, flag_load;
`ifdef MULTICYCLE_MOV_EN
    logic       dec_mov;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= FETCH;
            flags_reg   <= 4'b0000;
            cond_ex_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Condition is resolved once in DECODE so ALUWB is not affected by the EXEC flag update.
            if (state_reg == DECODE)
                cond_ex_reg <= cond_ex_next;
            if (flag_load[1])
                flags_reg[3:2] <= ALUFlags[3:2];
            if (flag_load[0])
                flags_reg[1:0] <= ALUFlags[1:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        next_pc    = 1'b0;
        ir_write   = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        case (state_reg)
            FETCH: begin
                next_pc = 1'b1; ir_write = 1'b1;
                alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
                state_next = DECODE;
            end
            DECODE: begin
                alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
                case (Op)
                    2'b01:   state_next = MEMADR;
                    2'b00:   state_next = Funct[5] ? EXECI : EXECR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_b  = 2'b01;
                state_next = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD:  begin adr_src = 1'b1; state_next = MEMWB; end
            MEMWB:  begin result_src = 2'b01; reg_w = 1'b1; state_next = FETCH; end
            MEMWR:  begin adr_src = 1'b1; mem_w = 1'b1; state_next = FETCH; end
            EXECR:  begin alu_op = 1'b1; state_next = ALUWB; end
            EXECI:  begin alu_src_b = 2'b01; alu_op = 1'b1; state_next = ALUWB; end
            ALUWB:  begin reg_w = 1'b1; state_next = FETCH; end
            BRANCH: begin
                alu_src_b = 2'b01; result_src = 2'b10; branch = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        dec_ctrl      = ALU_ADD;
        dec_supported = 1'b1;
        dec_arith     = 1'b0;
        dec_cmp       = 1'b0;
`ifdef MULTICYCLE_MOV_EN
        dec_mov       = 1'b0;
`endif
        case (Funct[4:1])
            4'b0100: begin dec_ctrl = ALU_ADD; dec_arith = 1'b1; end
            4'b0010: begin dec_ctrl = ALU_SUB; dec_arith = 1'b1; end
            4'b0000: dec_ctrl = ALU_AND;
            4'b1100: dec_ctrl = ALU_ORR;
            4'b0001: begin
                if (EOR_EN) dec_ctrl = ALU_EOR;
                else        dec_supported = 1'b0;
            end
            4'b1010: begin dec_ctrl = ALU_SUB; dec_arith = 1'b1; dec_cmp = 1'b1; end
`ifdef MULTICYCLE_MOV_EN
            4'b1101: begin dec_ctrl = ALU_ADD; dec_mov = 1'b1; end
`endif
            default: dec_supported = 1'b0;
        endcase
    end

    // Writeback suppression must persist from EXEC into ALUWB.
    assign dp_step    = alu_op | (state_reg == ALUWB);
    assign ALUControl = (alu_op && dec_supported) ? dec_ctrl : ALU_ADD;
    assign flag_w     = (alu_op && dec_supported) ? {Funct[0], Funct[0] & dec_arith} : 2'b00;
    assign NoWrite    = dp_step & (~dec_supported | dec_cmp);
`ifdef MULTICYCLE_MOV_EN
    assign MOVInstr   = dp_step & dec_mov;
`else
    assign MOVInstr   = 1'b0;
`endif

    always_comb begin
        case (Cond)
            4'b0000: cond_ex_next = flags_reg[2];
            4'b0001: cond_ex_next = ~flags_reg[2];
            4'b0010: cond_ex_next = flags_reg[1];
            4'b0011: cond_ex_next = ~flags_reg[1];
            4'b0100: cond_ex_next = flags_reg[3];
            4'b0101: cond_ex_next = ~flags_reg[3];
            4'b0110: cond_ex_next = flags_reg[0];
            4'b0111: cond_ex_next = ~flags_reg[0];
            4'b1000: cond_ex_next = flags_reg[1] & ~flags_reg[2];
            4'b1001: cond_ex_next = ~flags_reg[1] | flags_reg[2];
            4'b1010: cond_ex_next = (flags_reg[3] == flags_reg[0]);
            4'b1011: cond_ex_next = (flags_reg[3] != flags_reg[0]);
            4'b1100: cond_ex_next = ~flags_reg[2] & (flags_reg[3] == flags_reg[0]);
            4'b1101: cond_ex_next = flags_reg[2] | (flags_reg[3] != flags_reg[0]);
            4'b1110: cond_ex_next = 1'b1;
            default: cond_ex_next = 1'b0;
        endcase
    end

    assign cond_ex = (state_reg == DECODE) ? cond_ex_next : cond_ex_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_flag_load
        assign flag_load[gi] = flag_w[gi] & cond_ex;
    end

    assign pcs       = ((Rd == PC_REG) & reg_w) | branch;
    assign PCWrite   = rst_n & (next_pc | (pcs & cond_ex));
    assign IRWrite   = rst_n & ir_write;
    assign RegWrite  = rst_n & reg_w & cond_ex & ~NoWrite;
    assign MemWrite  = rst_n & mem_w & cond_ex;
    assign AdrSrc    = adr_src;
    assign ALUSrcA   = alu_src_a;
    assign ALUSrcB   = alu_src_b;
    assign ResultSrc = result_src;
    assign ImmSrc    = Op;
    assign RegSrc    = {Op == 2'b01, Op == 2'b10};
    assign Flags     = flags_reg;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed instruction table, a reset-abort sequence and random
// instruction streams checked cycle by cycle against an instruction-level model (3- and 2-bit ALUControl).
module tb_multicycle_control_unit;
`ifdef MULTICYCLE_MOV_EN
    localparam bit MOV_EN = 1'b1;
`else
    localparam bit MOV_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;

    logic a_PCWrite, a_IRWrite, a_RegWrite, a_MemWrite, a_AdrSrc, a_ALUSrcA, a_NoWrite, a_MOVInstr;
    logic [1:0] a_ALUSrcB, a_ResultSrc, a_ImmSrc, a_RegSrc;
    logic [2:0] a_ALUControl;
    logic [3:0] a_Flags;
    logic b_PCWrite, b_IRWrite, b_RegWrite, b_MemWrite, b_AdrSrc, b_ALUSrcA, b_NoWrite, b_MOVInstr;
    logic [1:0] b_ALUSrcB, b_ResultSrc, b_ImmSrc, b_RegSrc;
    logic [1:0] b_ALUControl;
    logic [3:0] b_Flags;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALUCTRL_W(3), .PC_REG(4'd15)) dut (
        .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
        .PCWrite(a_PCWrite), .IRWrite(a_IRWrite), .RegWrite(a_RegWrite), .MemWrite(a_MemWrite),
        .AdrSrc(a_AdrSrc), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ResultSrc(a_ResultSrc),
        .ImmSrc(a_ImmSrc), .RegSrc(a_RegSrc), .ALUControl(a_ALUControl), .NoWrite(a_NoWrite),
        .MOVInstr(a_MOVInstr), .Flags(a_Flags));

    multicycle_control_unit #(.ALUCTRL_W(2), .PC_REG(4'd15)) dut2 (
        .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
        .PCWrite(b_PCWrite), .IRWrite(b_IRWrite), .RegWrite(b_RegWrite), .MemWrite(b_MemWrite),
        .AdrSrc(b_AdrSrc), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ResultSrc(b_ResultSrc),
        .ImmSrc(b_ImmSrc), .RegSrc(b_RegSrc), .ALUControl(b_ALUControl), .NoWrite(b_NoWrite),
        .MOVInstr(b_MOVInstr), .Flags(b_Flags));

    typedef struct packed {
        logic pcw, irw, rw, mw, adrsrc, srca;
        logic [1:0] srcb, res, imm, regsrc;
        logic [2:0] alu;
        logic nowr, mov;
        logic [3:0] flags;
    } obs_t;

    typedef struct packed {
        logic [2:0] alu;
        logic nowr, mov;
        logic [1:0] fw;
    } dec_t;

    typedef struct {
        logic [3:0] c;
        logic [1:0] o;
        logic [5:0] f;
        logic [3:0] r, af;
        logic [3:0] exp_flags;
        logic [2:0] exp_we;
        logic [2:0] exp_alu;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [3:0] mflags_a, mflags_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] fl);
        logic n, z, cy, v;
        {n, z, cy, v} = fl;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic dec_t decode(input logic [5:0] f, input bit eor_ok);
        dec_t d;
        bit ok, arith;
        d = '0; ok = 1; arith = 0;
        case (f[4:1])
            4'b0100: begin d.alu = 3'd0; arith = 1; end
            4'b0010: begin d.alu = 3'd1; arith = 1; end
            4'b0000: d.alu = 3'd2;
            4'b1100: d.alu = 3'd3;
            4'b0001: if (eor_ok) d.alu = 3'd4; else ok = 0;
            4'b1010: begin d.alu = 3'd1; arith = 1; d.nowr = 1; end
            4'b1101: if (MOV_EN) begin d.alu = 3'd0; d.mov = 1; end else ok = 0;
            default: ok = 0;
        endcase
        if (ok) d.fw = {f[0], f[0] & arith};
        else begin d.alu = 3'd0; d.nowr = 1; d.fw = 2'b00; end
        return d;
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [5:0] f);
        case (o)
            2'b01:   return f[0] ? 5 : 4;
            2'b00:   return 4;
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    // Expected outputs in step k of an instruction (0 = fetch, 1 = decode, then per instruction class).
    function automatic obs_t model(input int k, input logic [1:0] o, input logic [5:0] f,
                                   input logic [3:0] rd, input logic cex, input logic [3:0] fl,
                                   input bit eor_ok);
        obs_t e;
        dec_t d;
        e = '0;
        e.imm = o;
        e.regsrc = {o == 2'b01, o == 2'b10};
        e.flags = fl;
        d = decode(f, eor_ok);
        if (k == 0) begin
            e.pcw = 1; e.irw = 1; e.srca = 1; e.srcb = 2'b10; e.res = 2'b10;
        end else if (k == 1) begin
            e.srca = 1; e.srcb = 2'b10; e.res = 2'b10;
        end else begin
            case (o)
                2'b01: begin
                    if (k == 2) e.srcb = 2'b01;
                    else if (f[0] && k == 3) e.adrsrc = 1;
                    else if (f[0]) begin
                        e.res = 2'b01; e.rw = cex; e.pcw = cex && (rd == 4'd15);
                    end else begin
                        e.adrsrc = 1; e.mw = cex;
                    end
                end
                2'b00: begin
                    e.nowr = d.nowr; e.mov = d.mov;
                    if (k == 2) begin
                        e.srcb = {1'b0, f[5]}; e.alu = d.alu;
                    end else begin
                        e.rw = cex && !d.nowr; e.pcw = cex && (rd == 4'd15);
                    end
                end
                default: begin
                    e.srcb = 2'b01; e.res = 2'b10; e.pcw = cex;
                end
            endcase
        end
        return e;
    endfunction

    task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] af,
                             output obs_t last, output logic [2:0] alu_ex);
        int lat;
        logic cex_a, cex_b;
        obs_t ea, eb, oa, ob;
        dec_t da, db;
        lat = latency(o, f);
        cex_a = cond_ok(c, mflags_a);
        cex_b = cond_ok(c, mflags_b);
        alu_ex = 3'd0;
        last = '0;
        for (int k = 0; k < lat; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                rst_n = 1'b1; Cond = c; Op = o; Funct = f; Rd = r;
            end
            ALUFlags = (k == 2) ? af : 4'($urandom);
            @(negedge clk);
            ea = model(k, o, f, r, cex_a, mflags_a, 1'b1);
            eb = model(k, o, f, r, cex_b, mflags_b, 1'b0);
            oa = {a_PCWrite, a_IRWrite, a_RegWrite, a_MemWrite, a_AdrSrc, a_ALUSrcA, a_ALUSrcB,
                  a_ResultSrc, a_ImmSrc, a_RegSrc, a_ALUControl, a_NoWrite, a_MOVInstr, a_Flags};
            ob = {b_PCWrite, b_IRWrite, b_RegWrite, b_MemWrite, b_AdrSrc, b_ALUSrcA, b_ALUSrcB,
                  b_ResultSrc, b_ImmSrc, b_RegSrc, 1'b0, b_ALUControl, b_NoWrite, b_MOVInstr, b_Flags};
            check($sformatf("step%0d_op%0d_w3", k, o), 32'(oa), 32'(ea));
            check($sformatf("step%0d_op%0d_w2", k, o), 32'(ob), 32'(eb));
            if (o == 2'b00 && k == 2) begin
                alu_ex = a_ALUControl;
                da = decode(f, 1'b1);
                db = decode(f, 1'b0);
                if (cex_a && da.fw[1]) mflags_a[3:2] = af[3:2];
                if (cex_a && da.fw[0]) mflags_a[1:0] = af[1:0];
                if (cex_b && db.fw[1]) mflags_b[3:2] = af[3:2];
                if (cex_b && db.fw[0]) mflags_b[1:0] = af[1:0];
            end
            last = oa;
        end
    endtask

    vec_t tbl [13];
    obs_t last;
    logic [2:0] alu_ex;

    initial begin
        tbl[0]  = '{4'hE, 2'd1, 6'b011001, 4'd3,  4'h0, 4'b0000, 3'b100, 3'd0}; // LDR
        tbl[1]  = '{4'hE, 2'd1, 6'b011000, 4'd4,  4'h0, 4'b0000, 3'b010, 3'd0}; // STR
        tbl[2]  = '{4'hE, 2'd0, 6'b000101, 4'd2,  4'h4, 4'b0100, 3'b100, 3'd1}; // SUBS -> Z
        tbl[3]  = '{4'h0, 2'd0, 6'b001000, 4'd5,  4'hF, 4'b0100, 3'b100, 3'd0}; // ADDEQ
        tbl[4]  = '{4'h1, 2'd0, 6'b001000, 4'd5,  4'hF, 4'b0100, 3'b000, 3'd0}; // ADDNE
        tbl[5]  = '{4'hE, 2'd0, 6'b010101, 4'd0,  4'h2, 4'b0010, 3'b000, 3'd1}; // CMP
        tbl[6]  = '{4'hE, 2'd2, 6'b100000, 4'd0,  4'h0, 4'b0010, 3'b001, 3'd0}; // B
        tbl[7]  = '{4'hE, 2'd0, 6'b000101, 4'd1,  4'h4, 4'b0100, 3'b100, 3'd1}; // SUBS -> Z
        tbl[8]  = '{4'h1, 2'd2, 6'b100000, 4'd0,  4'h0, 4'b0100, 3'b000, 3'd0}; // BNE, Z set
        tbl[9]  = '{4'hE, 2'd0, 6'b000011, 4'd6,  4'h8, 4'b1000, 3'b100, 3'd4}; // EORS
        tbl[10] = '{4'hE, 2'd0, 6'b011010, 4'd7,  4'h0, 4'b1000,
                    MOV_EN ? 3'b100 : 3'b000, 3'd0};                            // MOV
        tbl[11] = '{4'hE, 2'd3, 6'b000000, 4'd0,  4'h0, 4'b1000, 3'b000, 3'd0}; // Op=11
        tbl[12] = '{4'hE, 2'd1, 6'b011001, 4'd15, 4'h0, 4'b1000, 3'b101, 3'd0}; // LDR PC

        rst_n = 1'b0; Cond = 4'h0; Op = 2'b00; Funct = 6'h0; Rd = 4'h0; ALUFlags = 4'h0;
        mflags_a = 4'h0; mflags_b = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we_forced", {28'h0, a_PCWrite, a_IRWrite, a_RegWrite, a_MemWrite}, 32'h0);
        check("rst_flags", {28'h0, a_Flags}, 32'h0);

        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i].c, tbl[i].o, tbl[i].f, tbl[i].r, tbl[i].af, last, alu_ex);
            $display("vec %0d cond=%h op=%0d funct=%b flags=%b we=%b alu=%0d", i, tbl[i].c,
                     tbl[i].o, tbl[i].f, last.flags, {last.rw, last.mw, last.pcw}, alu_ex);
            check($sformatf("tbl%0d_flags", i), {28'h0, last.flags}, {28'h0, tbl[i].exp_flags});
            check($sformatf("tbl%0d_we", i), {29'h0, last.rw, last.mw, last.pcw},
                  {29'h0, tbl[i].exp_we});
            check($sformatf("tbl%0d_alu", i), {29'h0, alu_ex}, {29'h0, tbl[i].exp_alu});
        end

        // Reset in the MEMWR step of a store must suppress the memory write and clear the flags.
        @(posedge clk); #1 Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd2;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        $display("abort store: memwrite=%b regwrite=%b pcwrite=%b", a_MemWrite, a_RegWrite, a_PCWrite);
        check("abort_we_w3", {28'h0, a_PCWrite, a_IRWrite, a_RegWrite, a_MemWrite}, 32'h0);
        check("abort_we_w2", {28'h0, b_PCWrite, b_IRWrite, b_RegWrite, b_MemWrite}, 32'h0);
        mflags_a = 4'h0; mflags_b = 4'h0;
        run_instr(4'hE, 2'd3, 6'b000000, 4'd0, 4'h0, last, alu_ex);
        $display("after abort: flags=%b", last.flags);

        for (int n = 0; n < 250; n++) begin
            logic [3:0] c, r, af;
            logic [1:0] o;
            logic [5:0] f;
            c  = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
            o  = 2'($urandom);
            f  = 6'($urandom);
            r  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            af = 4'($urandom);
            run_instr(c, o, f, r, af, last, alu_ex);
            $display("rnd %0d cond=%h op=%0d funct=%b rd=%0d flags=%b", n, c, o, f, r, last.flags);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
